character_ring_buffer: RTL

Parametrised circular character buffer for the keyboard peripheral. It is the next-generation replacement for the flat-addressed character register file. Incoming key codes are pushed at a tail pointer and consumed in order from a head pointer. Two random-access read ports, indexed relative to the head, let the CPU side peek at queued characters without popping them. It adds occupancy tracking, full/empty status, a selectable overflow policy and sticky error flags.

---
 rtl/character_ring_buffer_if.sv | 39 +++
 rtl/character_ring_buffer.sv | 107 ++++++++++
 2 files changed

// File: rtl/character_ring_buffer_if.sv
// Host-side bundle for the keyboard character ring buffer:
// push/pop/clear controls, two peek ports and status.
interface character_ring_buffer_if #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
);
  logic                 clear;
  logic                 push;
  logic [WIDTH-1:0]     data_in;
  logic                 pop;
  logic [ADDR_BITS-1:0] select_a;
  logic [ADDR_BITS-1:0] select_b;
  logic [WIDTH-1:0]     out_a;
  logic [WIDTH-1:0]     out_b;
  logic                 valid_a;
  logic                 valid_b;
  logic [WIDTH-1:0]     head_out;
  logic [ADDR_BITS:0]   count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output clear, push, data_in, pop,
    output select_a, select_b,
    input  out_a, out_b, valid_a, valid_b,
    input  head_out, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  clear, push, data_in, pop,
    input  select_a, select_b,
    output out_a, out_b, valid_a, valid_b,
    output head_out, count, empty, full,
    output overflow, underflow
  );
endinterface

// File: rtl/character_ring_buffer.sv
// Circular key-code queue with head-relative peek ports,
// occupancy tracking and sticky overflow/underflow flags.
module character_ring_buffer #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5,
  parameter int OVERWRITE = 0
) (
  input  logic clock,
  input  logic reset,
  character_ring_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C =
    (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] CNT_ONE =
    (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE =
    ADDR_BITS'(1);
  localparam logic OVW = (OVERWRITE != 0);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] rd_q, rd_d;
  logic [ADDR_BITS-1:0] wr_q, wr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic full_w, empty_w;
  logic do_wr, rd_adv;
  logic [ADDR_BITS-1:0] idx_a, idx_b;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A full push still writes when paired with a pop or
  // when overwriting; the oldest entry is then retired.
  assign do_wr  = bus.push &&
                  (!full_w || bus.pop || OVW);
  assign rd_adv = (bus.pop && !empty_w) ||
                  (bus.push && full_w &&
                   !bus.pop && OVW);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (do_wr)  wr_d = wr_q + PTR_ONE;
      if (rd_adv) rd_d = rd_q + PTR_ONE;
      if (do_wr && !rd_adv)
        count_d = count_q + CNT_ONE;
      else if (rd_adv && !do_wr)
        count_d = count_q - CNT_ONE;
      if (bus.push && full_w && !bus.pop)
        ovf_d = 1'b1;
      if (bus.pop && empty_w)
        udf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (!bus.clear && do_wr) begin
      mem_q[wr_q] <= bus.data_in;
    end
  end

  assign idx_a = rd_q + bus.select_a;
  assign idx_b = rd_q + bus.select_b;

  assign bus.out_a     = mem_q[idx_a];
  assign bus.out_b     = mem_q[idx_b];
  assign bus.head_out  = mem_q[rd_q];
  assign bus.valid_a   = ({1'b0, bus.select_a} < count_q);
  assign bus.valid_b   = ({1'b0, bus.select_b} < count_q);
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;
  assign bus.full      = full_w;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule
